// File: rtl/lr_train_sequencer_pkg.sv
// Shared constants, FSM state encoding and row word-index helpers for the
// linear-regression training sequencer.
package lr_pkg;

   localparam int unsigned MAX_FEATURES = 8;
   localparam int unsigned WORD_W       = 16;
   localparam int unsigned ROW_WORDS    = MAX_FEATURES + 1;
   localparam int unsigned ROW_W        = WORD_W * ROW_WORDS;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
      S_RUN,
      S_CAPTURE,
      S_DRAIN,
      S_DONE
   } state_t;

   // Word k of a row occupies [word_msb(k):word_lsb(k)]; k=0 is the MS word.
   function automatic int unsigned word_lsb(input int unsigned k);
      return ROW_W - WORD_W * (k + 1);
   endfunction

   function automatic int unsigned word_msb(input int unsigned k);
      return ROW_W - 1 - WORD_W * k;
   endfunction

   function automatic logic [WORD_W-1:0] row_word(input logic [ROW_W-1:0] row,
                                                  input int unsigned     k);
      return WORD_W'(row >> word_lsb(k));
   endfunction

endpackage

// File: rtl/lr_train_sequencer_row_packer.sv
// Row register shared by LOAD (packing host words, MS word first) and
// DRAIN (unpacking the captured weight vector, MS word first).
module lr_row_packer #(
   parameter int unsigned NWORDS = 9,
   parameter int unsigned WORD_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       load,
   input  logic                       shift,
   input  logic [NWORDS*WORD_W-1:0]   load_data,
   input  logic [WORD_W-1:0]          shift_in,
   output logic [NWORDS*WORD_W-1:0]   row
);

   localparam int unsigned ROW_W = NWORDS * WORD_W;

   // Shifting left moves the oldest word toward the MS end.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         row <= '0;
      end else if (load) begin
         row <= load_data;
      end else if (shift) begin
         row <= {row[ROW_W-WORD_W-1:0], shift_in};
      end
   end

endmodule

// File: rtl/lr_train_sequencer.sv
// Load/train/readback sequencer for the linear-regression training core.
// Optional RUN watchdog enabled by defining LR_SEQ_TIMEOUT_EN.
module lr_train_sequencer #(
   parameter int unsigned MAX_DP         = 6,
   parameter int unsigned MAX_FEATURES   = lr_pkg::MAX_FEATURES,
   parameter int unsigned ADDR_WIDTH     = 3,
   parameter int unsigned WORD_W         = lr_pkg::WORD_W,
   parameter int unsigned ROW_W          = WORD_W * (MAX_FEATURES + 1),
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                  CLK,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] cfg_dps,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WORD_W-1:0]     in_data,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   output logic [ROW_W-1:0]      ram_wdata,
   output logic                  core_enable,
   input  logic [ADDR_WIDTH-1:0] core_addr,
   input  logic                  core_fin,
   input  logic [ROW_W-1:0]      core_wt,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORD_W-1:0]     out_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   import lr_pkg::*;

   localparam int unsigned           WCW       = $clog2(MAX_FEATURES + 1);
   localparam logic [WCW-1:0]        LAST_WORD = WCW'(MAX_FEATURES);
   localparam logic [ADDR_WIDTH-1:0] DP_MAX    = ADDR_WIDTH'(MAX_DP);

   state_t                state;
   logic [WCW-1:0]        word_cnt;
   logic [ADDR_WIDTH-1:0] row_cnt;
   logic [ADDR_WIDTH-1:0] dps_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ROW_W-1:0]      row_q;
   logic                  cfg_ok;
   logic                  load_acc;
   logic                  drain_acc;
   logic                  pk_clear;
   logic                  pk_load;
   logic                  pk_shift;
   logic [WORD_W-1:0]     pk_in;
   logic                  timeout;

   assign cfg_ok    = (cfg_dps != '0) && (cfg_dps <= DP_MAX);
   assign load_acc  = (state == S_LOAD) && in_valid && in_ready;
   assign drain_acc = (state == S_DRAIN) && out_valid && out_ready;
   assign pk_clear  = (state == S_IDLE) && start && cfg_ok;
   assign pk_load   = (state == S_RUN) && core_fin;
   assign pk_shift  = load_acc || drain_acc;
   assign pk_in     = (state == S_LOAD) ? in_data : '0;

   lr_row_packer #(
      .NWORDS (MAX_FEATURES + 1),
      .WORD_W (WORD_W)
   ) u_packer (
      .clk       (CLK),
      .rst       (rst),
      .clear     (pk_clear),
      .load      (pk_load),
      .shift     (pk_shift),
      .load_data (core_wt),
      .shift_in  (pk_in),
      .row       (row_q)
   );

   // The core owns the RAM address for the whole of RUN, with no register in the path.
   assign ram_addr  = (state == S_RUN) ? core_addr : addr_q;
   assign ram_wdata = row_q;
   assign out_data  = row_word(row_q, 0);

`ifdef LR_SEQ_TIMEOUT_EN
   localparam int unsigned RCW = $clog2(TIMEOUT_CYCLES + 1);

   logic [RCW-1:0] run_cnt;

   // Counts RUN cycles; leaves RUN on its last value, so it never wraps.
   always_ff @(posedge CLK) begin
      if (rst || (state != S_RUN)) begin
         run_cnt <= '0;
      end else begin
         run_cnt <= run_cnt + RCW'(1);
      end
   end

   assign timeout = (run_cnt == RCW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   // Sequencer FSM with registered outputs.
   always_ff @(posedge CLK) begin
      if (rst) begin
         state       <= S_IDLE;
         word_cnt    <= '0;
         row_cnt     <= '0;
         dps_q       <= '0;
         addr_q      <= '0;
         in_ready    <= 1'b0;
         ram_we      <= 1'b0;
         core_enable <= 1'b0;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         ram_we <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (cfg_ok) begin
                     dps_q    <= cfg_dps;
                     row_cnt  <= '0;
                     word_cnt <= '0;
                     in_ready <= 1'b1;
                     busy     <= 1'b1;
                     state    <= S_LOAD;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (load_acc) begin
                  if (word_cnt == LAST_WORD) begin
                     word_cnt <= '0;
                     in_ready <= 1'b0;
                     ram_we   <= 1'b1;
                     addr_q   <= row_cnt;
                     state    <= S_WRITE;
                  end else begin
                     word_cnt <= word_cnt + WCW'(1);
                  end
               end
            end
            S_WRITE: begin
               if (row_cnt == dps_q) begin
                  core_enable <= 1'b1;
                  state       <= S_RUN;
               end else begin
                  row_cnt  <= row_cnt + ADDR_WIDTH'(1);
                  in_ready <= 1'b1;
                  state    <= S_LOAD;
               end
            end
            S_RUN: begin
               if (core_fin) begin
                  core_enable <= 1'b0;
                  state       <= S_CAPTURE;
               end else if (timeout) begin
                  core_enable <= 1'b0;
                  busy        <= 1'b0;
                  err         <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            S_CAPTURE: begin
               word_cnt  <= '0;
               out_valid <= 1'b1;
               state     <= S_DRAIN;
            end
            S_DRAIN: begin
               if (drain_acc) begin
                  if (word_cnt == LAST_WORD) begin
                     out_valid <= 1'b0;
                     done      <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     word_cnt <= word_cnt + WCW'(1);
                  end
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lr_train_sequencer.sv
// Directed bench for lr_train_sequencer with write/readback scoreboards.
// Adds a watchdog scenario when LR_SEQ_TIMEOUT_EN is defined.
module tb_lr_train_sequencer;

   logic         CLK;
   logic         rst;
   logic         start;
   logic [2:0]   cfg_dps;
   logic         in_valid;
   logic         in_ready;
   logic [15:0]  in_data;
   logic [2:0]   ram_addr;
   logic         ram_we;
   logic [143:0] ram_wdata;
   logic         core_enable;
   logic [2:0]   core_addr;
   logic         core_fin;
   logic [143:0] core_wt;
   logic         out_valid;
   logic         out_ready;
   logic [15:0]  out_data;
   logic         busy;
   logic         done;
   logic         err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_we_cyc = 0;
   int en_rise_cyc = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   bit stall = 0;
   logic en_q = 1'b0;
   logic stall_q = 1'b0;
   logic [15:0] held = '0;

   logic [2:0]   wq_addr[$];
   logic [143:0] wq_data[$];
   logic [15:0]  oq[$];

   lr_train_sequencer #(.TIMEOUT_CYCLES(100)) dut (
      .CLK         (CLK),
      .rst         (rst),
      .start       (start),
      .cfg_dps     (cfg_dps),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .ram_addr    (ram_addr),
      .ram_we      (ram_we),
      .ram_wdata   (ram_wdata),
      .core_enable (core_enable),
      .core_addr   (core_addr),
      .core_fin    (core_fin),
      .core_wt     (core_wt),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Host readback side: continuous or randomly stalled out_ready.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge CLK);
         #1;
         out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   // Output monitor: pops scoreboards and checks the RUN address mux.
   always @(negedge CLK) begin
      cyc++;
      if (ram_we === 1'b1) begin
         last_we_cyc = cyc;
         chk("we_expected", 144'(wq_addr.size() != 0), 144'(1));
         if (wq_addr.size() != 0) begin
            chk("we_addr", 144'(ram_addr), 144'(wq_addr.pop_front()));
            chk("we_data", ram_wdata, wq_data.pop_front());
         end
      end
      if (core_enable === 1'b1) begin
         if (en_q !== 1'b1) en_rise_cyc = cyc;
         chk("mux_addr", 144'(ram_addr), 144'(core_addr));
         chk("mux_we", 144'(ram_we), 144'(0));
      end
      en_q = core_enable;
      if (stall_q === 1'b1 && out_valid === 1'b1) chk("out_stable", 144'(out_data), 144'(held));
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         chk("out_expected", 144'(oq.size() != 0), 144'(1));
         if (oq.size() != 0) chk("out_data", 144'(out_data), 144'(oq.pop_front()));
      end
      stall_q = out_valid && !out_ready;
      held = out_data;
      if (done === 1'b1) begin
         done_cnt++;
         chk("done_after_drain", 144'(oq.size()), 144'(0));
      end
      if (err === 1'b1) err_cnt++;
   end

   function automatic logic [15:0] word_val(input int r, input int k, input bit vary,
                                            input logic [15:0] y, input logic [15:0] x);
      if (r == 0) return vary ? 16'(16'hA000 + k) : 16'h0000;
      if (k == 0) return vary ? 16'(y + 16'(r)) : y;
      return vary ? 16'(x + 16'(r * 16 + k)) : x;
   endfunction

   task automatic send_word(input logic [15:0] w, input bit gaps);
      int t;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge CLK);
            #1;
         end
      end
      in_valid = 1'b1;
      in_data  = w;
      t = 0;
      @(negedge CLK);
      while (!in_ready && t < 50) begin
         @(negedge CLK);
         t++;
      end
      chk("in_accept", 144'(in_ready), 144'(1));
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic start_run(input int n);
      cfg_dps = 3'(n);
      start   = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      @(negedge CLK);
      chk("start_in_ready", 144'(in_ready), 144'(1));
      chk("start_busy", 144'(busy), 144'(1));
      @(posedge CLK);
      #1;
   endtask

   // Loads rows 0..n; a start pulse with a bad config is issued mid-load and must be ignored.
   task automatic load_rows(input int n, input bit gaps, input bit vary,
                            input logic [15:0] y, input logic [15:0] x);
      logic [143:0] row;
      for (int r = 0; r <= n; r++) begin
         row = '0;
         for (int k = 0; k < 9; k++) row[143-16*k -: 16] = word_val(r, k, vary, y, x);
         wq_addr.push_back(3'(r));
         wq_data.push_back(row);
         for (int k = 0; k < 9; k++) begin
            if (r == 1 && k == 0) begin
               start   = 1'b1;
               cfg_dps = 3'd0;
            end
            send_word(word_val(r, k, vary, y, x), gaps);
            start = 1'b0;
         end
      end
   endtask

   task automatic arm_fin(input logic [143:0] wt);
      for (int k = 0; k < 9; k++) oq.push_back(wt[143-16*k -: 16]);
      core_wt  = wt;
      core_fin = 1'b1;
   endtask

   task automatic finish_run(input logic [143:0] wt, input bit early, input int e0);
      int t;
      if (!early) begin
         t = 0;
         @(negedge CLK);
         while (!core_enable && t < 100) begin
            @(negedge CLK);
            t++;
         end
         chk("enable_seen", 144'(core_enable), 144'(1));
         for (int a = 0; a <= 6; a++) begin
            @(posedge CLK);
            #1;
            core_addr = 3'(a);
         end
         arm_fin(wt);
      end
      t = 0;
      while (!done && t < 300) begin
         @(negedge CLK);
         t++;
      end
      chk("done_seen", 144'(done), 144'(1));
      @(posedge CLK);
      #1;
      core_fin  = 1'b0;
      core_addr = '0;
      @(negedge CLK);
      chk("done_one_cycle", 144'(done), 144'(0));
      chk("idle_not_busy", 144'(busy), 144'(0));
      chk("enable_latency", 144'(en_rise_cyc - last_we_cyc), 144'(1));
      chk("writes_all_seen", 144'(wq_addr.size()), 144'(0));
      chk("outs_all_seen", 144'(oq.size()), 144'(0));
      chk("ignored_start_no_err", 144'(err_cnt), 144'(e0));
      @(posedge CLK);
      #1;
   endtask

   task automatic bad_start(input logic [2:0] c);
      cfg_dps = c;
      start   = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      @(negedge CLK);
      chk("bad_cfg_err", 144'(err), 144'(1));
      chk("bad_cfg_busy", 144'(busy), 144'(0));
      chk("bad_cfg_in_ready", 144'(in_ready), 144'(0));
      @(posedge CLK);
      #1;
      @(negedge CLK);
      chk("bad_cfg_err_pulse", 144'(err), 144'(0));
      chk("bad_cfg_still_idle", 144'(busy), 144'(0));
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [143:0] wt;
      int d0;
      int e0;
      int t;
      rst = 1'b1;
      start = 1'b0;
      cfg_dps = '0;
      in_valid = 1'b0;
      in_data = '0;
      core_addr = '0;
      core_fin = 1'b0;
      core_wt = '0;

      // Reset state
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_in_ready", 144'(in_ready), 144'(0));
      chk("rst_ram_we", 144'(ram_we), 144'(0));
      chk("rst_core_enable", 144'(core_enable), 144'(0));
      chk("rst_out_valid", 144'(out_valid), 144'(0));
      chk("rst_busy", 144'(busy), 144'(0));
      chk("rst_done", 144'(done), 144'(0));
      chk("rst_err", 144'(err), 144'(0));
      chk("rst_ram_addr", 144'(ram_addr), 144'(0));
      chk("rst_ram_wdata", ram_wdata, 144'(0));
      chk("rst_out_data", 144'(out_data), 144'(0));
      @(posedge CLK);
      #1;
      rst = 1'b0;

      // Rejected configurations
      bad_start(3'd0);
      bad_start(3'd7);

      // Nominal run: six points, weights 1..9
      for (int k = 0; k < 9; k++) wt[143-16*k -: 16] = 16'(k + 1);
      e0 = err_cnt;
      start_run(6);
      load_rows(6, 1'b0, 1'b0, 16'h0100, 16'h0010);
      finish_run(wt, 1'b0, e0);

      // Backpressure on both sides, varied data
      stall = 1'b1;
      for (int k = 0; k < 9; k++) wt[143-16*k -: 16] = 16'($urandom);
      e0 = err_cnt;
      start_run(6);
      load_rows(6, 1'b1, 1'b1, 16'h8123, 16'h7FF0);
      finish_run(wt, 1'b0, e0);
      stall = 1'b0;

      // Reset after four words of row 2: no write for that row
      start_run(3);
      load_rows(1, 1'b0, 1'b1, 16'h1111, 16'h2222);
      for (int k = 0; k < 4; k++) send_word(16'hDEAD, 1'b0);
      rst = 1'b1;
      @(posedge CLK);
      #1;
      @(negedge CLK);
      chk("midrst_busy", 144'(busy), 144'(0));
      chk("midrst_in_ready", 144'(in_ready), 144'(0));
      chk("midrst_ram_we", 144'(ram_we), 144'(0));
      chk("midrst_queue", 144'(wq_addr.size()), 144'(0));
      @(posedge CLK);
      #1;
      rst = 1'b0;
      @(posedge CLK);
      #1;

      // Fresh run with core_fin already high when RUN is entered
      for (int k = 0; k < 9; k++) wt[143-16*k -: 16] = 16'(16'hF000 + k);
      e0 = err_cnt;
      start_run(4);
      arm_fin(wt);
      load_rows(4, 1'b1, 1'b1, 16'h0042, 16'h0101);
      finish_run(wt, 1'b1, e0);

`ifdef LR_SEQ_TIMEOUT_EN
      // Watchdog: core never finishes
      d0 = done_cnt;
      start_run(1);
      load_rows(1, 1'b0, 1'b0, 16'h0100, 16'h0010);
      t = 0;
      @(negedge CLK);
      while (!core_enable && t < 100) begin
         @(negedge CLK);
         t++;
      end
      chk("to_enable_seen", 144'(core_enable), 144'(1));
      t = 0;
      while (!err && t < 300) begin
         @(negedge CLK);
         t++;
      end
      chk("to_cycles", 144'(t), 144'(100));
      chk("to_core_enable", 144'(core_enable), 144'(0));
      chk("to_busy", 144'(busy), 144'(0));
      chk("to_out_valid", 144'(out_valid), 144'(0));
      repeat (5) @(negedge CLK);
      chk("to_no_done", 144'(done_cnt), 144'(d0));
      chk("to_no_readback", 144'(out_valid), 144'(0));
`else
      d0 = done_cnt;
      chk("final_done_count", 144'(d0), 144'(3));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
